// File: rtl/axis_rr_pkg.sv
// Shared definitions for the AXI-Stream round-robin arbiter/distributor pair:
// packet-tracking FSM state type and pointer-width helper.
package axis_rr_pkg;

  // Packet-tracking state: IDLE between packets, PACKET while one is open.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_PACKET = 1'b1
  } fsm_state_t;

  // Width of a channel index; never collapses below one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 32'd1) begin
      return 32'd1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/axis_rr_out_reg.sv
// Single-entry registered output stage with valid/ready handshaking.
// Sustains one beat per cycle: it reloads in the same cycle it drains.
module axis_rr_out_reg
  import axis_rr_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PAYLOAD_W-1:0] s_payload,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PAYLOAD_W-1:0] m_payload
);

  logic                 valid_r;
  logic [PAYLOAD_W-1:0] payload_r;
  logic                 load_s;

  // Free slot when empty or when the held beat leaves this cycle.
  assign s_ready   = !valid_r || m_ready;
  assign load_s    = s_valid && s_ready;
  assign m_valid   = valid_r;
  assign m_payload = payload_r;

  // Valid flag: set on load, cleared on drain without a simultaneous reload.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
    end else if (m_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: captured on load only, so it stays stable while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      payload_r <= '0;
    end else if (load_s) begin
      payload_r <= s_payload;
    end else begin
      payload_r <= payload_r;
    end
  end

endmodule

// File: rtl/axis_round_robin_distributor.sv
// 1-to-N AXI-Stream packet distributor. Whole packets are steered to the
// downstream channels in strict round-robin order; the channel pointer
// advances only after a tlast beat is accepted, so packets are never split.
module axis_round_robin_distributor
  import axis_rr_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = 8,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic [CHANNEL_NUM-1:0] m_tvalid,
  output logic                   m_tlast,
  input  logic [CHANNEL_NUM-1:0] m_tready,
  output logic [CHANNEL_NUM-1:0] sel_o,
  output logic                   busy_o
);

  localparam int unsigned PTR_W     = ptr_width(CHANNEL_NUM);
  localparam int unsigned PAYLOAD_W = DATA_WIDTH + 1 + PTR_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CHANNEL_NUM - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]       ptr_r;
  fsm_state_t             state_r;
  fsm_state_t             state_nxt_s;
  logic                   reg_s_ready_s;
  logic                   reg_m_valid_s;
  logic                   sel_ready_s;
  logic                   accept_s;
  logic                   eop_accept_s;
  logic [PAYLOAD_W-1:0]   in_payload_s;
  logic [PAYLOAD_W-1:0]   out_payload_s;
  logic [PTR_W-1:0]       dest_s;
  logic [CHANNEL_NUM-1:0] dest_hot_s;
  logic [CHANNEL_NUM-1:0] sel_hot_s;

  // Upstream ready comes only from registered state and m_tready, and is
  // held low during reset.
  assign s_tready     = rst_n_i && reg_s_ready_s;
  assign accept_s     = s_tvalid && s_tready;
  assign eop_accept_s = accept_s && s_tlast;

  // Payload carries the destination captured from the pointer at accept time.
  assign in_payload_s = {s_tdata, s_tlast, ptr_r};
  assign m_tdata      = out_payload_s[PAYLOAD_W-1 -: DATA_WIDTH];
  assign m_tlast      = out_payload_s[PTR_W];
  assign dest_s       = out_payload_s[PTR_W-1:0];

  axis_rr_out_reg #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_out_reg (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .s_valid   (s_tvalid),
    .s_ready   (reg_s_ready_s),
    .s_payload (in_payload_s),
    .m_valid   (reg_m_valid_s),
    .m_ready   (sel_ready_s),
    .m_payload (out_payload_s)
  );

  // One-hot decode of the held destination and of the round-robin pointer.
  always_comb begin
    dest_hot_s = '0;
    sel_hot_s  = '0;
    for (int i = 0; i < int'(CHANNEL_NUM); i++) begin
      dest_hot_s[i] = (dest_s == PTR_W'(i));
      sel_hot_s[i]  = (ptr_r == PTR_W'(i));
    end
  end

  // Only the ready of the channel that owns the held beat counts.
  assign sel_ready_s = |(dest_hot_s & m_tready);
  assign m_tvalid    = reg_m_valid_s ? dest_hot_s : '0;
  assign sel_o       = sel_hot_s;
  assign busy_o      = (state_r == ST_PACKET);

  // Round-robin pointer: one step per accepted tlast beat, wrapping at the end.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_r <= '0;
    end else if (eop_accept_s) begin
      if (ptr_r == PTR_LAST) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= ptr_r + PTR_ONE;
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Packet FSM next state: open on a non-last accept, close on a last accept.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !s_tlast) begin
          state_nxt_s = ST_PACKET;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PACKET: begin
        if (eop_accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PACKET;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Packet FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

endmodule

// File: tb/tb_axis_round_robin_distributor.sv
// Self-checking bench for axis_round_robin_distributor (4 channels, 32-bit).
// A queue-based reference model records every accepted upstream beat with
// the channel it must reach (packet index mod 4) and matches it against each
// completed downstream transfer; directed tests cover reset, stalls and
// back-to-back packets.
module tb_axis_round_robin_distributor;

  localparam int CH = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [CH-1:0] m_tvalid;
  logic          m_tlast;
  logic [CH-1:0] m_tready = '0;
  logic [CH-1:0] sel_o;
  logic          busy_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    pkt_cnt = 0;
  bit    in_pkt = 1'b0;
  bit    rand_done = 1'b0;

  axis_round_robin_distributor #(
    .CHANNEL_NUM (CH),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .sel_o    (sel_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (decided at the negedge).
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = s_tready;
      tick();
    end
    if (!acc) check_eq("send_timeout", {63'd0, acc}, 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model and protocol monitor, sampled at the falling edge.
  initial begin
    logic          prev_stall;
    logic [CH-1:0] prev_valid;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          pend;
    logic [DW-1:0] pend_data;
    beat_t         e;
    prev_stall = 1'b0;
    pend       = 1'b0;
    prev_valid = '0;
    prev_data  = '0;
    prev_last  = 1'b0;
    pend_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        pkt_cnt    = 0;
        in_pkt     = 1'b0;
        pend       = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check_eq("onehot", {63'd0, ($countones(m_tvalid) <= 1)}, 64'd1);
        check_eq("sel", {60'd0, sel_o}, 64'd1 << (pkt_cnt % CH));
        check_eq("busy", {63'd0, busy_o}, {63'd0, in_pkt});
        check_eq("s_tready", {63'd0, s_tready},
                 {63'd0, (m_tvalid == '0) || ((m_tvalid & m_tready) != '0)});
        if (prev_stall) begin
          check_eq("hold_valid", {60'd0, m_tvalid}, {60'd0, prev_valid});
          check_eq("hold_data", {32'd0, m_tdata}, {32'd0, prev_data});
          check_eq("hold_last", {63'd0, m_tlast}, {63'd0, prev_last});
        end
        if (pend) begin
          check_eq("lat_valid", {63'd0, (m_tvalid != '0)}, 64'd1);
          check_eq("lat_data", {32'd0, m_tdata}, {32'd0, pend_data});
        end
        pend = 1'b0;
        if ((m_tvalid & m_tready) != '0) begin
          check_eq("q_nonempty", {63'd0, (exp_q.size() != 0)}, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("xfer_ch", 64'(onehot_idx(m_tvalid)), 64'(e.ch));
            check_eq("xfer_data", {32'd0, m_tdata}, {32'd0, e.data});
            check_eq("xfer_last", {63'd0, m_tlast}, {63'd0, e.last});
          end
        end
        prev_stall = (m_tvalid != '0) && ((m_tvalid & m_tready) == '0);
        prev_valid = m_tvalid;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (s_tvalid && s_tready) begin
          e.ch   = pkt_cnt % CH;
          e.data = s_tdata;
          e.last = s_tlast;
          exp_q.push_back(e);
          pend      = 1'b1;
          pend_data = s_tdata;
          if (s_tlast) begin
            pkt_cnt++;
            in_pkt = 1'b0;
          end else begin
            in_pkt = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with all readies high so s_tready must be forced low.
    m_tready = 4'hF;
    #3;
    check_eq("rst_s_tready", {63'd0, s_tready}, 64'd0);
    check_eq("rst_m_tvalid", {60'd0, m_tvalid}, 64'd0);
    check_eq("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    check_eq("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    check_eq("rst_sel", {60'd0, sel_o}, 64'd1);
    check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Four back-to-back 3-beat packets onto channels 0..3.
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 3; b++) begin
        check_eq("t1_s_tready", {63'd0, s_tready}, 64'd1);
        send_beat(32'(p * 16 + b), (b == 2));
        s_tvalid = 1'b1;
        check_eq("t1_m_tvalid", {60'd0, m_tvalid}, 64'd1 << p);
        check_eq("t1_m_tdata", {32'd0, m_tdata}, 64'(p * 16 + b));
      end
    end
    s_tvalid = 1'b0;
    check_eq("t1_sel_wrap", {60'd0, sel_o}, 64'd1);
    tick();

    // Single-beat packets A0..A5 onto channels 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) begin
      send_beat(32'(8'hA0 + i), 1'b1);
      check_eq("t2_m_tvalid", {60'd0, m_tvalid}, 64'd1 << (i % CH));
      check_eq("t2_m_tdata", {32'd0, m_tdata}, 64'(8'hA0 + i));
      check_eq("t2_busy", {63'd0, busy_o}, 64'd0);
    end
    tick();

    // Channel 1 stalled while its packet B0..B2 is pending; other readies high.
    do_reset();
    m_tready = 4'hF;
    send_beat(32'h01, 1'b1);
    m_tready = 4'b1101;
    send_beat(32'hB0, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'hB1;
    s_tlast  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_stall_valid", {60'd0, m_tvalid}, 64'b0010);
      check_eq("t3_stall_data", {32'd0, m_tdata}, 64'hB0);
      check_eq("t3_stall_ready", {63'd0, s_tready}, 64'd0);
      tick();
    end
    m_tready = 4'hF;
    tick();
    check_eq("t3_d1_data", {32'd0, m_tdata}, 64'hB1);
    check_eq("t3_d1_valid", {60'd0, m_tvalid}, 64'b0010);
    s_tdata = 32'hB2;
    s_tlast = 1'b1;
    tick();
    check_eq("t3_d2_data", {32'd0, m_tdata}, 64'hB2);
    check_eq("t3_d2_last", {63'd0, m_tlast}, 64'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tick();
    check_eq("t3_drained", {60'd0, m_tvalid}, 64'd0);

    // Reset asserted while beat 2 of a 4-beat packet sits on channel 2.
    do_reset();
    m_tready = 4'hF;
    send_beat(32'h11, 1'b1);
    send_beat(32'h22, 1'b1);
    send_beat(32'hC0, 1'b0);
    send_beat(32'hC1, 1'b0);
    check_eq("t5_pre_valid", {60'd0, m_tvalid}, 64'b0100);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", {60'd0, m_tvalid}, 64'd0);
    check_eq("t5_rst_ready", {63'd0, s_tready}, 64'd0);
    check_eq("t5_rst_sel", {60'd0, sel_o}, 64'd1);
    check_eq("t5_rst_busy", {63'd0, busy_o}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_beat(32'hD0, 1'b1);
    check_eq("t5_after_valid", {60'd0, m_tvalid}, 64'b0001);
    check_eq("t5_after_data", {32'd0, m_tdata}, 64'hD0);
    tick();

    // Random packet lengths, upstream gaps and downstream readiness.
    do_reset();
    rand_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = int'($urandom_range(1, 5));
          for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_beat($urandom, (b == len - 1));
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          m_tready = CH'($urandom);
          tick();
        end
      end
    join
    m_tready = 4'hF;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check_eq("rand_drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("rand_pkt_count", 64'(pkt_cnt), 64'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
